// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, poison word, sizing helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE   = 2'd0,
      DMEM_ACCESS = 2'd1,
      DMEM_RESP   = 2'd2
   } dmem_state_t;

   // Returned for reads that fall outside the populated memory range.
   localparam logic [15:0] DMEM_POISON = 16'hDEAD;

   // Index width that stays at least one bit wide for degenerate sizes.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/dmem_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (mod N) wins, one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed and advances ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          gnt_vld
);

   // Scan offsets 0..N-1 from ptr; the first requesting slot takes the grant.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!gnt_vld && req[j] && (((int'(ptr) + i) % N) == j)) begin
               gnt[j]  = 1'b1;
               gnt_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-ported data memory serving NUM_THREADS LSU ports one transaction at a time (DMEM_OOB_CHECK_EN adds range checking).
// Latency: accept at edge N, write pulse / read data valid after edge N+MEM_LATENCY.
// Backpressure: read data held until read_resp_rdy; all request rdy low while busy.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int NUM_THREADS     = 4,
   parameter int DATA_WIDTH      = 16,
   parameter int DATA_ADDR_WIDTH = 8,
   parameter int DEPTH           = 256,
   parameter int MEM_LATENCY     = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       read_req_rdy       [NUM_THREADS-1:0],
   input  logic [DATA_ADDR_WIDTH-1:0] read_req_addr      [NUM_THREADS-1:0],
   input  logic                       read_req_addr_val  [NUM_THREADS-1:0],
   input  logic                       read_resp_rdy      [NUM_THREADS-1:0],
   output logic [DATA_WIDTH-1:0]      read_resp_data     [NUM_THREADS-1:0],
   output logic                       read_resp_data_val [NUM_THREADS-1:0],
   output logic                       write_req_rdy      [NUM_THREADS-1:0],
   input  logic [DATA_ADDR_WIDTH-1:0] write_req_addr     [NUM_THREADS-1:0],
   input  logic [DATA_WIDTH-1:0]      write_req_data     [NUM_THREADS-1:0],
   input  logic                       write_req_val      [NUM_THREADS-1:0],
   output logic                       write_resp_val     [NUM_THREADS-1:0],
   output logic                       busy,
   output logic                       oob_err
);

   localparam int TW = clog2_min1(NUM_THREADS);
   localparam int IW = clog2_min1(DEPTH);
   localparam int LW = clog2_min1(MEM_LATENCY);

   dmem_state_t                state, state_nxt;
   logic [TW-1:0]              rr_ptr, cur_tid, gnt_idx;
   logic [LW-1:0]              lat_cnt;
   logic                       cur_is_wr;
   logic [DATA_ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0]      cur_wdata, resp_data, read_word;
   logic [NUM_THREADS-1:0]     req_vec, gnt_oh, wr_pulse;
   logic                       gnt_vld, accept, commit, oob_hit, mem_we;
   logic [IW-1:0]              mem_idx;

   // Not reset: contents survive reset, only the control path restarts.
   logic [DATA_WIDTH-1:0]      mem [DEPTH];

   assign mem_idx = cur_addr[IW-1:0];

   // A thread competes if it has either a read or a write pending.
   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         req_vec[i] = read_req_addr_val[i] | write_req_val[i];
      end
   end

   rr_arbiter #(
      .N  (NUM_THREADS),
      .PW (TW)
   ) u_arb (
      .req     (req_vec),
      .ptr     (rr_ptr),
      .gnt     (gnt_oh),
      .gnt_vld (gnt_vld)
   );

   // Convert the one-hot grant into a thread index for muxing and latching.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (gnt_oh[i]) gnt_idx = TW'(i);
      end
   end

`ifdef DMEM_OOB_CHECK_EN
   localparam logic [DATA_ADDR_WIDTH:0] DEPTH_W = (DATA_ADDR_WIDTH+1)'(DEPTH);
   logic [DATA_WIDTH-1:0] poison_word;

   assign oob_hit = ({1'b0, cur_addr} >= DEPTH_W);

   // Poison pattern repeated (or truncated) to fill the data width.
   always_comb begin
      poison_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         poison_word[i] = DMEM_POISON[i % 16];
      end
   end

   assign read_word = oob_hit ? poison_word : mem[mem_idx];

   // Sticky error: set on any out-of-range commit, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oob_err <= 1'b0;
      end else if (commit && oob_hit) begin
         oob_err <= 1'b1;
      end
   end
`else
   // Addresses wrap onto the low index bits; upper bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cur_addr;
   assign oob_hit          = 1'b0;
   assign read_word        = mem[mem_idx];
   assign oob_err          = 1'b0;
`endif

   assign mem_we = commit && cur_is_wr && !oob_hit;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= DMEM_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept on grant, count down the access, hold read data until taken.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         DMEM_IDLE: begin
            if (gnt_vld && !reset) begin
               accept    = 1'b1;
               state_nxt = DMEM_ACCESS;
            end
         end
         DMEM_ACCESS: begin
            if (lat_cnt == '0) begin
               commit    = 1'b1;
               state_nxt = cur_is_wr ? DMEM_IDLE : DMEM_RESP;
            end
         end
         DMEM_RESP: begin
            if (read_resp_rdy[cur_tid]) state_nxt = DMEM_IDLE;
         end
         default: state_nxt = DMEM_IDLE;
      endcase
   end

   // Transaction registers, pointer advance, latency counter and write-done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         lat_cnt   <= '0;
         cur_tid   <= '0;
         cur_is_wr <= 1'b0;
         cur_addr  <= '0;
         cur_wdata <= '0;
         resp_data <= '0;
         wr_pulse  <= '0;
      end else begin
         wr_pulse <= '0;
         if (accept) begin
            cur_tid   <= gnt_idx;
            cur_is_wr <= write_req_val[gnt_idx];
            cur_addr  <= write_req_val[gnt_idx] ? write_req_addr[gnt_idx] : read_req_addr[gnt_idx];
            cur_wdata <= write_req_data[gnt_idx];
            rr_ptr    <= (gnt_idx == TW'(NUM_THREADS-1)) ? '0 : gnt_idx + 1'b1;
            lat_cnt   <= LW'(MEM_LATENCY-1);
         end else if (state == DMEM_ACCESS && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (commit) begin
            if (cur_is_wr) begin
               wr_pulse[cur_tid] <= 1'b1;
            end else begin
               resp_data <= read_word;
            end
         end
      end
   end

   // Memory write port; an aborted access never reaches commit so nothing lands.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= cur_wdata;
   end

   // Per-lane handshakes: only the granted lane sees rdy, only the owning lane sees data.
   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         write_req_rdy[i]      = (state == DMEM_IDLE) && !reset && gnt_oh[i] && write_req_val[i];
         read_req_rdy[i]       = (state == DMEM_IDLE) && !reset && gnt_oh[i] && !write_req_val[i];
         read_resp_data_val[i] = (state == DMEM_RESP) && (cur_tid == TW'(i));
         read_resp_data[i]     = read_resp_data_val[i] ? resp_data : '0;
         write_resp_val[i]     = wr_pulse[i];
      end
   end

   assign busy = (state != DMEM_IDLE);

endmodule
